// File: rtl/m_trap_sequencer_if.sv
// Pipeline/CSR-file side bundle of the machine-mode trap sequencer.
// master = sequencer, slave = pipeline + CSR file.
interface m_trap_sequencer_if #(
    parameter logic [1:0] XLEN = 2'd2
);
    localparam int unsigned W = 32'd1 << (32'(XLEN) + 32'd4);

    logic [3:0]   i_exc_code_fd;
    logic [W-1:0] i_exc_pc_fd;
    logic [3:0]   i_exc_code_em;
    logic [W-1:0] i_exc_pc_em;
    logic [W-1:0] i_exc_addr_em;
    logic         i_mret;
    logic         i_irq_ext;
    logic         i_irq_sw;
    logic [W-1:0] i_irq_pc;
    logic [W-1:0] i_mstatus;
    logic [W-1:0] i_mie;
    logic [W-1:0] i_mtvec;
    logic [W-1:0] i_mepc;

    logic         o_csr_we;
    logic [11:0]  o_csr_addr;
    logic [W-1:0] o_csr_wdata;
    logic         o_flush;
    logic         o_stall;
    logic         o_redirect_valid;
    logic [W-1:0] o_redirect_pc;
    logic         o_busy;

    modport master (
        input  i_exc_code_fd, i_exc_pc_fd, i_exc_code_em, i_exc_pc_em, i_exc_addr_em,
        input  i_mret, i_irq_ext, i_irq_sw, i_irq_pc,
        input  i_mstatus, i_mie, i_mtvec, i_mepc,
        output o_csr_we, o_csr_addr, o_csr_wdata, o_flush, o_stall,
        output o_redirect_valid, o_redirect_pc, o_busy
    );

    modport slave (
        output i_exc_code_fd, i_exc_pc_fd, i_exc_code_em, i_exc_pc_em, i_exc_addr_em,
        output i_mret, i_irq_ext, i_irq_sw, i_irq_pc,
        output i_mstatus, i_mie, i_mtvec, i_mepc,
        input  o_csr_we, o_csr_addr, o_csr_wdata, o_flush, o_stall,
        input  o_redirect_valid, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/m_trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret,
// writes the trap CSRs one per cycle, then redirects fetch.
module m_trap_sequencer #(
    parameter logic [1:0] XLEN = 2'd2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    m_trap_sequencer_if.master bus
);
    localparam int unsigned W = 32'd1 << (32'(XLEN) + 32'd4);

    localparam logic [3:0]  NO_E        = 4'hF;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, R_MSTAT, REDIR
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0] cause_q, epc_q, tval_q;
    logic         irq_q, mret_q;

    logic         trap_v, mret_v, accept;
    logic [W-1:0] cause_d, epc_d, tval_d;
    logic         irq_d;
    logic [W-1:0] mstat_trap, mstat_mret, tvec_base;

    logic unused_bits;
    assign unused_bits = ^{bus.i_mie, bus.i_mepc[0]};

    // Source arbitration and CSR value shaping
    always_comb begin
        logic em_v, fd_v, ext_v, sw_v;
        em_v    = (bus.i_exc_code_em != NO_E);
        fd_v    = (bus.i_exc_code_fd != NO_E);
        ext_v   = bus.i_irq_ext & bus.i_mstatus[3] & bus.i_mie[11];
        sw_v    = bus.i_irq_sw  & bus.i_mstatus[3] & bus.i_mie[3];
        trap_v  = em_v | fd_v | ext_v | sw_v;
        mret_v  = bus.i_mret & ~trap_v;
        accept  = (state_q == IDLE) & i_clk_en & ~i_rst & (trap_v | mret_v);

        cause_d = '0;
        epc_d   = '0;
        tval_d  = '0;
        irq_d   = 1'b0;
        if (em_v) begin
            cause_d = W'(bus.i_exc_code_em);
            epc_d   = bus.i_exc_pc_em;
            tval_d  = bus.i_exc_addr_em;
        end else if (fd_v) begin
            cause_d = W'(bus.i_exc_code_fd);
            epc_d   = bus.i_exc_pc_fd;
            tval_d  = bus.i_exc_pc_fd;
        end else if (ext_v) begin
            cause_d        = W'(4'd11);
            cause_d[W-1]   = 1'b1;
            epc_d          = bus.i_irq_pc;
            irq_d          = 1'b1;
        end else if (sw_v) begin
            cause_d        = W'(4'd3);
            cause_d[W-1]   = 1'b1;
            epc_d          = bus.i_irq_pc;
            irq_d          = 1'b1;
        end

        mstat_trap        = bus.i_mstatus;
        mstat_trap[7]     = bus.i_mstatus[3];
        mstat_trap[3]     = 1'b0;
        mstat_trap[12:11] = 2'b11;

        mstat_mret        = bus.i_mstatus;
        mstat_mret[3]     = bus.i_mstatus[7];
        mstat_mret[7]     = 1'b1;
        mstat_mret[12:11] = 2'b00;

        tvec_base = {bus.i_mtvec[W-1:2], 2'b00};
    end

    // State register and accept-cycle latches
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            irq_q   <= 1'b0;
            mret_q  <= 1'b0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            if (accept) begin
                cause_q <= cause_d;
                epc_q   <= epc_d;
                tval_q  <= tval_d;
                irq_q   <= irq_d;
                mret_q  <= mret_v;
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_d              = state_q;
        bus.o_csr_we         = 1'b0;
        bus.o_csr_addr       = '0;
        bus.o_csr_wdata      = '0;
        bus.o_flush          = accept;
        bus.o_stall          = (state_q != IDLE) | accept;
        bus.o_busy           = (state_q != IDLE);
        bus.o_redirect_valid = 1'b0;
        bus.o_redirect_pc    = '0;

        case (state_q)
            IDLE: begin
                if (accept) state_d = mret_v ? R_MSTAT : W_MEPC;
            end
            W_MEPC: begin
                bus.o_csr_we    = i_clk_en;
                bus.o_csr_addr  = CSR_MEPC;
                bus.o_csr_wdata = {epc_q[W-1:2], 2'b00};
                state_d         = W_MCAUSE;
            end
            W_MCAUSE: begin
                bus.o_csr_we    = i_clk_en;
                bus.o_csr_addr  = CSR_MCAUSE;
                bus.o_csr_wdata = cause_q;
                state_d         = W_MTVAL;
            end
            W_MTVAL: begin
                bus.o_csr_we    = i_clk_en;
                bus.o_csr_addr  = CSR_MTVAL;
                bus.o_csr_wdata = tval_q;
                state_d         = W_MSTAT;
            end
            W_MSTAT: begin
                bus.o_csr_we    = i_clk_en;
                bus.o_csr_addr  = CSR_MSTATUS;
                bus.o_csr_wdata = mstat_trap;
                state_d         = REDIR;
            end
            R_MSTAT: begin
                bus.o_csr_we    = i_clk_en;
                bus.o_csr_addr  = CSR_MSTATUS;
                bus.o_csr_wdata = mstat_mret;
                state_d         = REDIR;
            end
            REDIR: begin
                bus.o_redirect_valid = 1'b1;
                if (mret_q)
                    bus.o_redirect_pc = {bus.i_mepc[W-1:1], 1'b0};
                else if (irq_q && bus.i_mtvec[1:0] == 2'b01)
                    bus.o_redirect_pc = tvec_base + W'({cause_q[3:0], 2'b00});
                else
                    bus.o_redirect_pc = tvec_base;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_m_trap_sequencer.sv
// Scoreboard bench for m_trap_sequencer at W=32: stimulus pushes expected
// CSR writes / redirects with their cycle; a negedge monitor pops and compares.
module tb_m_trap_sequencer;
    localparam logic [3:0] NO_E = 4'hF;

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic i_clk, i_rst, i_clk_en;
    int   cyc, total, bad, t;
    exp_t sb[$];
    exp_t mon_e;

    m_trap_sequencer_if #(.XLEN(2'd1)) bus();

    m_trap_sequencer #(.XLEN(2'd1)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clk_en (i_clk_en),
        .bus      (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input bit r, input logic [11:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.is_redir = r;
        e.addr     = a;
        e.data     = d;
        e.cyc      = c;
        sb.push_back(e);
    endtask

    task automatic clear_src();
        bus.i_exc_code_fd = NO_E;
        bus.i_exc_code_em = NO_E;
        bus.i_mret        = 1'b0;
        bus.i_irq_ext     = 1'b0;
        bus.i_irq_sw      = 1'b0;
    endtask

    // Monitor: every write strobe or redirect must match the scoreboard head
    always @(negedge i_clk) begin
        if (bus.o_csr_we || bus.o_redirect_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got we=%0b addr=%0h data=%0h redir=%0b pc=%0h expected nothing (cycle %0d)",
                         bus.o_csr_we, bus.o_csr_addr, bus.o_csr_wdata,
                         bus.o_redirect_valid, bus.o_redirect_pc, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_kind", {62'd0, bus.o_redirect_valid, bus.o_csr_we},
                      mon_e.is_redir ? 64'd2 : 64'd1);
                if (mon_e.is_redir) begin
                    check("redir_pc", 64'(bus.o_redirect_pc), 64'(mon_e.data));
                end else begin
                    check("csr_addr", 64'(bus.o_csr_addr), 64'(mon_e.addr));
                    check($sformatf("csr_%0h_data", mon_e.addr), 64'(bus.o_csr_wdata), 64'(mon_e.data));
                end
                check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_clk_en = 1'b1;
        clear_src();
        bus.i_exc_pc_fd   = '0;
        bus.i_exc_pc_em   = '0;
        bus.i_exc_addr_em = '0;
        bus.i_irq_pc      = '0;
        bus.i_mstatus     = '0;
        bus.i_mie         = '0;
        bus.i_mtvec       = '0;
        bus.i_mepc        = '0;

        tick();
        tick();
        check("rst_busy",  64'(bus.o_busy), 64'd0);
        check("rst_stall", 64'(bus.o_stall), 64'd0);
        check("rst_flush", 64'(bus.o_flush), 64'd0);
        check("rst_addr",  64'(bus.o_csr_addr), 64'd0);
        check("rst_wdata", 64'(bus.o_csr_wdata), 64'd0);
        check("rst_rpc",   64'(bus.o_redirect_pc), 64'd0);
        i_rst = 1'b0;
        tick();

        // Load fault from E/M
        bus.i_mtvec = 32'h400; bus.i_mstatus = 32'h8;
        bus.i_exc_code_em = 4'd5; bus.i_exc_pc_em = 32'h100; bus.i_exc_addr_em = 32'h2003;
        #1; t = cyc;
        check("t1_flush", 64'(bus.o_flush), 64'd1);
        check("t1_stall", 64'(bus.o_stall), 64'd1);
        push(0, 12'h341, 32'h100,  t + 1);
        push(0, 12'h342, 32'h5,    t + 2);
        push(0, 12'h343, 32'h2003, t + 3);
        push(0, 12'h300, 32'h1880, t + 4);
        push(1, 12'h0,   32'h400,  t + 5);
        tick(); clear_src();
        check("t1_busy", 64'(bus.o_busy), 64'd1);
        check("t1_noflush", 64'(bus.o_flush), 64'd0);
        repeat (5) tick();
        check("t1_idle_busy", 64'(bus.o_busy), 64'd0);
        check("t1_idle_stall", 64'(bus.o_stall), 64'd0);

        // Simultaneous F/D and E/M faults: E/M wins
        bus.i_mstatus = 32'h0;
        bus.i_exc_code_fd = 4'd2; bus.i_exc_pc_fd = 32'h104;
        bus.i_exc_code_em = 4'd7; bus.i_exc_pc_em = 32'h100; bus.i_exc_addr_em = 32'h55;
        #1; t = cyc;
        push(0, 12'h341, 32'h100,  t + 1);
        push(0, 12'h342, 32'h7,    t + 2);
        push(0, 12'h343, 32'h55,   t + 3);
        push(0, 12'h300, 32'h1800, t + 4);
        push(1, 12'h0,   32'h400,  t + 5);
        tick(); clear_src();
        repeat (5) tick();
        check("t2_idle_busy", 64'(bus.o_busy), 64'd0);

        // Vectored external interrupt
        bus.i_mtvec = 32'h401; bus.i_mstatus = 32'h8; bus.i_mie = 32'h800;
        bus.i_irq_ext = 1'b1; bus.i_irq_pc = 32'h200;
        #1; t = cyc;
        check("t3_flush", 64'(bus.o_flush), 64'd1);
        push(0, 12'h341, 32'h200,      t + 1);
        push(0, 12'h342, 32'h8000000B, t + 2);
        push(0, 12'h343, 32'h0,        t + 3);
        push(0, 12'h300, 32'h1880,     t + 4);
        push(1, 12'h0,   32'h42C,      t + 5);
        tick(); clear_src();
        repeat (5) tick();

        // mret together with a software interrupt: interrupt taken, mret dropped
        bus.i_mie = 32'h8; bus.i_irq_sw = 1'b1; bus.i_mret = 1'b1; bus.i_irq_pc = 32'h300;
        #1; t = cyc;
        push(0, 12'h341, 32'h300,      t + 1);
        push(0, 12'h342, 32'h80000003, t + 2);
        push(0, 12'h343, 32'h0,        t + 3);
        push(0, 12'h300, 32'h1880,     t + 4);
        push(1, 12'h0,   32'h40C,      t + 5);
        tick(); clear_src();
        repeat (5) tick();

        // Plain mret
        bus.i_mie = 32'h0; bus.i_mstatus = 32'h1880; bus.i_mepc = 32'h204; bus.i_mret = 1'b1;
        #1; t = cyc;
        check("t5_stall", 64'(bus.o_stall), 64'd1);
        push(0, 12'h300, 32'h88,  t + 1);
        push(1, 12'h0,   32'h204, t + 2);
        tick(); clear_src();
        check("t5_busy1", 64'(bus.o_busy), 64'd1);
        tick();
        check("t5_busy2", 64'(bus.o_busy), 64'd1);
        tick();
        check("t5_idle_busy", 64'(bus.o_busy), 64'd0);
        check("t5_idle_stall", 64'(bus.o_stall), 64'd0);

        // Masked software interrupt (MIE=0)
        bus.i_mstatus = 32'h0; bus.i_mie = 32'h8; bus.i_irq_sw = 1'b1;
        #1;
        check("t6_flush", 64'(bus.o_flush), 64'd0);
        check("t6_stall", 64'(bus.o_stall), 64'd0);
        tick();
        check("t6_busy", 64'(bus.o_busy), 64'd0);
        clear_src(); bus.i_mie = 32'h0;

        // Reset during W_MCAUSE aborts the sequence
        bus.i_mstatus = 32'h8; bus.i_mtvec = 32'h400;
        bus.i_exc_code_em = 4'd5; bus.i_exc_pc_em = 32'h303; bus.i_exc_addr_em = 32'h10;
        #1; t = cyc;
        push(0, 12'h341, 32'h300, t + 1);
        push(0, 12'h342, 32'h5,   t + 2);
        tick(); clear_src();
        tick();
        i_rst = 1'b1;
        tick();
        check("t7_busy", 64'(bus.o_busy), 64'd0);
        check("t7_addr", 64'(bus.o_csr_addr), 64'd0);
        i_rst = 1'b0;
        repeat (6) tick();

        // Clock enable low for 3 cycles during W_MCAUSE
        bus.i_exc_code_em = 4'd13; bus.i_exc_pc_em = 32'h500; bus.i_exc_addr_em = 32'h600;
        #1; t = cyc;
        push(0, 12'h341, 32'h500,  t + 1);
        push(0, 12'h342, 32'hD,    t + 5);
        push(0, 12'h343, 32'h600,  t + 6);
        push(0, 12'h300, 32'h1880, t + 7);
        push(1, 12'h0,   32'h400,  t + 8);
        tick(); clear_src();
        tick();
        i_clk_en = 1'b0;
        #1;
        check("t8_we_gated", 64'(bus.o_csr_we), 64'd0);
        tick();
        tick();
        tick();
        i_clk_en = 1'b1;
        repeat (3) tick();
        check("t8_redir_busy", 64'(bus.o_busy), 64'd1);
        tick();
        check("t8_idle_busy", 64'(bus.o_busy), 64'd0);

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
